frame_deserializer: RTL and testbench
=====================================

# frame_deserializer

Parametrised serial-audio capture block that converts CHANNELS one-bit serial data lines into parallel signed words, framed by the falling edge of the word-clock latch. It supersedes the fixed two-channel 16-bit holder: it generalises word width, capture offset and channel count, and adds an atomic output update, a valid strobe, frame-error detection and lock tracking. It sits directly behind the DAC serial-bus input pins and feeds the parallel sample path.

## Interface
- CHANNELS, 2: number of serial data lines (ch0 = L, ch1 = R).
- OUT_BITS, 16: bits captured per channel, MSB first.
- FIRST_BIT, 13: counter value at which the MSB is sampled.
- CNT_BITS, 6: frame counter width; FIRST_BIT+OUT_BITS ≤ 2^CNT_BITS−2.
- i_clk  in  1  bit clock; one serial bit per rising edge.
- i_reset  in  1  reset, synchronous and active-high.
- i_latch  in  1  word-clock latch; its falling edge starts a frame.
- i_data  in  CHANNELS  serial data, bit c = channel c.
- o_data  out  CHANNELS*OUT_BITS  held words; channel c at [c*OUT_BITS +: OUT_BITS], two's complement.
- o_valid  out  1  one-cycle pulse when o_data updates.
- o_error  out  1  one-cycle pulse on a truncated frame.
- o_locked  out  1  high while frames arrive well-formed.

## Operation
- Edge detect: r_latch_d <= i_latch each cycle. An edge is registered at a posedge where r_latch_d=1 and i_latch=0.
- Counter: set to 0 on an edge. Otherwise it increments and saturates at 2^CNT_BITS−1. It never wraps.
- States:
  - IDLE: after reset. Enter WAIT on an edge.
  - WAIT: count < FIRST_BIT. Enter SHIFT when count reaches FIRST_BIT.
  - SHIFT: at each posedge with count = FIRST_BIT+k (k = 0..OUT_BITS−1), shift i_data[c] into lane c. Enter HOLD after k = OUT_BITS−1.
  - HOLD: transfer all lanes to o_data together and pulse o_valid. Stay in HOLD until the next edge, then enter WAIT.
- Truncated frame: an edge while in WAIT or SHIFT pulses o_error, discards the partial lanes, leaves o_data unchanged, and restarts in WAIT.
- Simultaneous edge and last SHIFT bit: the frame completes normally, with no error, and the new frame starts in WAIT.
- Lock:
  - o_locked rises with the second consecutive o_valid that has no intervening o_error.
  - It falls on o_error.
  - It also falls when the counter saturates (latch timeout); the state then returns to IDLE.
- Reset mid-frame: the frame is discarded and all state returns to its reset values.
- No sign extension or rounding. Serial bits beyond OUT_BITS are ignored.

## Timing
- Reset values (registered at the posedge with i_reset=1): o_data=0, o_valid=0, o_error=0, o_locked=0, state IDLE, counter saturated, r_latch_d=0. Because r_latch_d resets to 0, no false edge occurs on the first cycle after reset.
- Sampling: for an edge registered at posedge E, the bit at count c is sampled at posedge E+1+c. The MSB is sampled at E+1+FIRST_BIT and the LSB at P = E+FIRST_BIT+OUT_BITS.
- Output: o_data and o_valid change at posedge P+1. o_valid is high for exactly one cycle.
- Error: o_error is high for the cycle after posedge E when E truncates a frame.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package frame_deserializer_pkg: state encoding (IDLE, WAIT, SHIFT, HOLD) and the counter-saturation constant helper.
- Sub-module frame_shift_lane: one OUT_BITS shift register with a shift enable and a clear, instantiated CHANNELS times by a generate loop.
- The top level holds the edge detector, counter, FSM, output register and lock logic.

## Test plan
- Defaults, 32-cycle frames (i_latch 16 cycles low, 16 high); L stream 0x8001, R stream 0x7FFE sent MSB first from count 13 -> o_data = {0x7FFE, 0x8001}, o_valid at E+30; o_locked high after the second frame.
- Latch falls again at count 20 -> o_error pulse, o_data keeps its previous value, o_locked drops, the next full frame captures correctly.
- i_latch held constant for 70 cycles -> counter saturates, o_locked=0, no o_valid; the next edge recovers.
- Assert i_reset during SHIFT -> all outputs 0 the next cycle; no o_valid for that frame.
- CHANNELS=4, OUT_BITS=18, FIRST_BIT=12, CNT_BITS=6 -> four distinct 18-bit patterns land in their correct slices.
- Edge coincident with the LSB sample (frame length FIRST_BIT+OUT_BITS cycles) -> o_valid, no o_error, consecutive frames captured.

Source files
------------

// File: rtl/frame_deserializer_pkg.sv
// Shared definitions for the serial-audio frame deserializer:
// FSM state encoding and the frame-counter saturation value.
package frame_deserializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   function automatic int unsigned cnt_sat(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

endpackage

// File: rtl/frame_shift_lane.sv
// One serial lane: MSB-first shift register with synchronous clear.
module frame_shift_lane #(
   parameter int OUT_BITS = 16
) (
   input  logic                clk_i,
   input  logic                clear_i,
   input  logic                shift_i,
   input  logic                bit_i,
   output logic [OUT_BITS-1:0] word_o
);

   logic [OUT_BITS-1:0] word_q;

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         word_q <= '0;
      end else if (shift_i) begin
         word_q <= {word_q[OUT_BITS-2:0], bit_i};
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/frame_deserializer.sv
// Captures CHANNELS serial lines into parallel words framed by the falling
// edge of the word-clock latch, with valid/error strobes and lock tracking.
module frame_deserializer
   import frame_deserializer_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int OUT_BITS  = 16,
   parameter int FIRST_BIT = 13,
   parameter int CNT_BITS  = 6
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_latch,
   input  logic [CHANNELS-1:0]          i_data,
   output logic [CHANNELS*OUT_BITS-1:0] o_data,
   output logic                         o_valid,
   output logic                         o_error,
   output logic                         o_locked
);

   localparam logic [CNT_BITS-1:0] CNT_MAX   = CNT_BITS'(cnt_sat(CNT_BITS));
   localparam logic [CNT_BITS-1:0] FIRST_CNT = CNT_BITS'(FIRST_BIT);
   localparam logic [CNT_BITS-1:0] LAST_CNT  = CNT_BITS'(FIRST_BIT + OUT_BITS - 1);

   state_e                        state_q;
   logic                          latch_q;
   logic [CNT_BITS-1:0]           cnt_q, cnt_d;
   logic                          done_q;
   logic                          good_q;
   logic [CHANNELS*OUT_BITS-1:0]  data_q;
   logic                          valid_q;
   logic                          error_q;
   logic                          locked_q;

   logic                          fall_w;
   logic                          shift_w;
   logic                          last_w;
   logic                          trunc_w;
   logic                          timeout_w;
   logic                          lane_clear;
   logic                          lane_shift;
   logic [CHANNELS*OUT_BITS-1:0]  lanes_w;

   always_comb begin
      fall_w    = latch_q & ~i_latch;
      shift_w   = ((state_q == ST_WAIT) && (cnt_q == FIRST_CNT)) || (state_q == ST_SHIFT);
      last_w    = shift_w && (cnt_q == LAST_CNT);
      // An edge landing on the final bit completes the frame rather than truncating it.
      trunc_w   = fall_w && ((state_q == ST_WAIT) || (state_q == ST_SHIFT)) && !last_w;
      timeout_w = !fall_w && (cnt_q == CNT_MAX);
      if (fall_w) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign lane_clear = i_reset | trunc_w;
   assign lane_shift = shift_w & ~trunc_w;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      frame_shift_lane #(
         .OUT_BITS(OUT_BITS)
      ) u_lane (
         .clk_i   (i_clk),
         .clear_i (lane_clear),
         .shift_i (lane_shift),
         .bit_i   (i_data[c]),
         .word_o  (lanes_w[c*OUT_BITS +: OUT_BITS])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         latch_q  <= 1'b0;
         cnt_q    <= CNT_MAX;
         done_q   <= 1'b0;
         good_q   <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         latch_q <= i_latch;
         cnt_q   <= cnt_d;
         done_q  <= last_w;
         valid_q <= done_q;
         error_q <= trunc_w;
         if (done_q) begin
            data_q <= lanes_w;
         end

         if (fall_w) begin
            state_q <= ST_WAIT;
         end else if (timeout_w) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_WAIT:  if (cnt_q == FIRST_CNT) state_q <= last_w ? ST_HOLD : ST_SHIFT;
               ST_SHIFT: if (last_w) state_q <= ST_HOLD;
               default:  ;
            endcase
         end

         // Lock needs two completed frames back to back; any error or timeout restarts it.
         if (trunc_w || timeout_w) begin
            locked_q <= 1'b0;
            good_q   <= 1'b0;
         end else if (done_q) begin
            if (good_q) locked_q <= 1'b1;
            good_q <= 1'b1;
         end
      end
   end

   assign o_data   = data_q;
   assign o_valid  = valid_q;
   assign o_error  = error_q;
   assign o_locked = locked_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Randomized bench for frame_deserializer: two configurations share one
// stimulus stream and are checked against a frame-level reference model.
module tb_frame_deserializer;

   localparam int MAXN = 4096;
   localparam int A_CH = 2, A_OB = 16, A_FB = 13;
   localparam int B_CH = 4, B_OB = 18, B_FB = 12;
   localparam int CB   = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, lat_i;
   logic [3:0]  dat_i;
   logic [31:0] a_data;
   logic        a_valid, a_error, a_locked;
   logic [71:0] b_data;
   logic        b_valid, b_error, b_locked;

   frame_deserializer #(.CHANNELS(A_CH), .OUT_BITS(A_OB), .FIRST_BIT(A_FB), .CNT_BITS(CB)) u_dut_a (
      .i_clk(clk), .i_reset(rst_i), .i_latch(lat_i), .i_data(dat_i[1:0]),
      .o_data(a_data), .o_valid(a_valid), .o_error(a_error), .o_locked(a_locked));

   frame_deserializer #(.CHANNELS(B_CH), .OUT_BITS(B_OB), .FIRST_BIT(B_FB), .CNT_BITS(CB)) u_dut_b (
      .i_clk(clk), .i_reset(rst_i), .i_latch(lat_i), .i_data(dat_i),
      .o_data(b_data), .o_valid(b_valid), .o_error(b_error), .o_locked(b_locked));

   logic        stim_lat[MAXN];
   logic        stim_rst[MAXN];
   logic [3:0]  stim_dat[MAXN];
   int          n;

   logic [71:0] obs_d[2][MAXN];
   logic        obs_v[2][MAXN];
   logic        obs_e[2][MAXN];
   logic        obs_l[2][MAXN];

   logic        mfall[MAXN];
   logic        mev[MAXN];
   logic        mee[MAXN];
   logic [71:0] mword[MAXN];

   int vectors, miscompares;

   task automatic check(input string tag, input int t, input logic [71:0] got, input logic [71:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, t, got, exp);
      end
   endtask

   task automatic push(input logic l, input logic r);
      if (n < MAXN) begin
         stim_lat[n] = l;
         stim_rst[n] = r;
         stim_dat[n] = 4'($urandom);
         n++;
      end
   endtask

   // Latch low for 'low' cycles then high for the rest; edge lands on the first low cycle.
   task automatic frame(input int low, input int len, output int e);
      e = n;
      for (int i = 0; i < len; i++) push(i >= low, 1'b0);
   endtask

   task automatic put_word(input int e, input int fb, input int ob, input int lane, input logic [31:0] w);
      for (int k = 0; k < ob; k++) begin
         if (e + 1 + fb + k < MAXN) stim_dat[e + 1 + fb + k][lane] = w[ob - 1 - k];
      end
   endtask

   task automatic run_model(input int d, input int ch, input int ob, input int fb);
      int          last, p, maxc;
      logic        ok, prev, lock, good, to;
      logic [71:0] w, word;
      string       pfx;
      pfx  = (d == 0) ? "A" : "B";
      maxc = (1 << CB) - 1;
      for (int t = 0; t < n; t++) begin
         prev     = (t == 0) ? 1'b0 : (stim_rst[t-1] ? 1'b0 : stim_lat[t-1]);
         mfall[t] = !stim_rst[t] && prev && !stim_lat[t];
         mev[t]   = 1'b0;
         mee[t]   = 1'b0;
         mword[t] = '0;
      end
      // An edge less than a full capture window after the previous one truncates it.
      last = -1;
      for (int t = 0; t < n; t++) begin
         if (stim_rst[t]) last = -1;
         else if (mfall[t]) begin
            if (last >= 0 && t - last < fb + ob) mee[t] = 1'b1;
            last = t;
         end
      end
      for (int e = 0; e < n; e++) begin
         if (mfall[e]) begin
            p  = e + fb + ob;
            ok = (p + 1 < n);
            for (int u = e + 1; u <= p + 1 && u < n; u++) begin
               if (u < p && mfall[u]) ok = 1'b0;
               if (stim_rst[u]) ok = 1'b0;
            end
            if (ok) begin
               w = '0;
               for (int c = 0; c < ch; c++)
                  for (int k = 0; k < ob; k++)
                     w[c*ob + ob - 1 - k] = stim_dat[e + 1 + fb + k][c];
               mev[p+1]   = 1'b1;
               mword[p+1] = w;
            end
         end
      end
      word = '0; lock = 1'b0; good = 1'b0; last = -1;
      for (int t = 0; t < n; t++) begin
         if (stim_rst[t]) begin
            word = '0; lock = 1'b0; good = 1'b0; last = -1;
         end else begin
            to = !mfall[t] && (last < 0 || t - last - 1 >= maxc);
            if (mev[t]) word = mword[t];
            if (mee[t] || to) begin
               lock = 1'b0; good = 1'b0;
            end else if (mev[t]) begin
               if (good) lock = 1'b1;
               good = 1'b1;
            end
            if (mfall[t]) last = t;
         end
         check({pfx, ".valid"},  t, 72'(obs_v[d][t]), 72'(mev[t]));
         check({pfx, ".error"},  t, 72'(obs_e[d][t]), 72'(mee[t]));
         check({pfx, ".locked"}, t, 72'(obs_l[d][t]), 72'(lock));
         check({pfx, ".data"},   t, obs_d[d][t], word);
      end
   endtask

   int e, e1, e2, etr, t_to, t_rst, eb, ec, len, low;
   logic [17:0] bp[4];

   initial begin
      vectors = 0; miscompares = 0; n = 0;
      bp[0] = 18'h20001; bp[1] = 18'h15555; bp[2] = 18'h0F0F0; bp[3] = 18'h3C3C3;

      for (int i = 0; i < 4; i++) push(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) push(1'b1, 1'b0);
      // Directed 32-cycle frames with L=0x8001, R=0x7FFE.
      for (int f = 0; f < 4; f++) begin
         frame(16, 32, e);
         put_word(e, A_FB, A_OB, 0, 32'h8001);
         put_word(e, A_FB, A_OB, 1, 32'h7FFE);
         if (f == 0) e1 = e;
         if (f == 1) e2 = e;
      end
      // Truncated frame: next edge at count 20.
      frame(10, 21, etr);
      for (int f = 0; f < 3; f++) frame(16, 32, e);
      t_to = n;
      for (int i = 0; i < 70; i++) push(1'b1, 1'b0);
      for (int f = 0; f < 3; f++) frame(16, 32, e);
      // Reset in the middle of the shift window.
      frame(16, 32, e);
      t_rst = e + 20;
      stim_rst[t_rst] = 1'b1;
      for (int f = 0; f < 3; f++) frame(16, 32, e);
      // Four-lane directed frames.
      for (int f = 0; f < 2; f++) begin
         frame(16, 32, e);
         for (int c = 0; c < 4; c++) put_word(e, B_FB, B_OB, c, {14'd0, bp[c]});
         if (f == 0) eb = e;
      end
      // Frames exactly FIRST_BIT+OUT_BITS long for the two-lane block.
      for (int f = 0; f < 5; f++) begin
         frame(10, A_FB + A_OB, e);
         if (f == 0) ec = e;
      end
      frame(16, 32, e);
      while (n < MAXN - 120) begin
         len = $urandom_range(20, 40);
         low = $urandom_range(1, len - 1);
         frame(low, len, e);
         if ($urandom_range(0, 24) == 0) stim_rst[e + $urandom_range(0, len - 1)] = 1'b1;
         if ($urandom_range(0, 19) == 0)
            for (int i = 0; i < 70; i++) push(1'b1, 1'b0);
      end

      rst_i = 1'b1; lat_i = 1'b1; dat_i = '0;
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         rst_i = stim_rst[t]; lat_i = stim_lat[t]; dat_i = stim_dat[t];
         @(posedge clk);
         #1;
         obs_d[0][t] = {40'd0, a_data}; obs_v[0][t] = a_valid; obs_e[0][t] = a_error; obs_l[0][t] = a_locked;
         obs_d[1][t] = b_data;          obs_v[1][t] = b_valid; obs_e[1][t] = b_error; obs_l[1][t] = b_locked;
      end

      run_model(0, A_CH, A_OB, A_FB);
      run_model(1, B_CH, B_OB, B_FB);

      check("A.reset_data",   3,          obs_d[0][3], 72'd0);
      check("A.first_valid",  e1 + 30,    72'(obs_v[0][e1 + 30]), 72'd1);
      check("A.first_word",   e1 + 30,    obs_d[0][e1 + 30], 72'h7FFE8001);
      check("A.unlocked_1st", e1 + 30,    72'(obs_l[0][e1 + 30]), 72'd0);
      check("A.locked_2nd",   e2 + 30,    72'(obs_l[0][e2 + 30]), 72'd1);
      check("A.trunc_error",  etr + 21,   72'(obs_e[0][etr + 21]), 72'd1);
      check("A.trunc_hold",   etr + 21,   obs_d[0][etr + 21], 72'h7FFE8001);
      check("A.trunc_unlock", etr + 21,   72'(obs_l[0][etr + 21]), 72'd0);
      check("A.timeout_lock", t_to + 69,  72'(obs_l[0][t_to + 69]), 72'd0);
      check("A.reset_mid",    t_rst,      obs_d[0][t_rst], 72'd0);
      check("B.four_lanes",   eb + 31,    obs_d[1][eb + 31], {bp[3], bp[2], bp[1], bp[0]});
      check("A.coinc_valid",  ec + 30,    72'(obs_v[0][ec + 30]), 72'd1);
      check("A.coinc_noerr",  ec + 29,    72'(obs_e[0][ec + 29]), 72'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
